// File: rtl/complex_mult_pipe_if.sv
// Streaming bus for complex_mult_pipe: operand handshake in, scaled result handshake out,
// plus the sticky-overflow status and its clear.
interface complex_mult_pipe_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_re;
  logic signed [WIDTH-1:0] a_im;
  logic signed [WIDTH-1:0] b_re;
  logic signed [WIDTH-1:0] b_im;
  logic                    conj_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] m_re;
  logic signed [WIDTH-1:0] m_im;
  logic                    ovf;
  logic                    ovf_sticky;
  logic                    clr;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready, clr,
    input  in_ready, out_valid, m_re, m_im, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready, clr,
    output in_ready, out_valid, m_re, m_im, ovf, ovf_sticky
  );
endinterface

// File: rtl/complex_mult_pipe.sv
// Three-stage complex multiplier (a*b or a*conj(b)) with rounding, arithmetic shift,
// optional saturation and per-sample / sticky overflow flags. All stages stall together.
module complex_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int SHIFT = 9,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input logic            clock,
  input logic            reset_n,
  complex_mult_pipe_if.slave bus
);
  localparam int PRW = 2 * WIDTH;
  localparam int PW  = 2 * WIDTH + 2;

  localparam logic signed [PW-1:0] MAX_V = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] RND_V =
    (ROUND != 0 && SHIFT > 0) ? (PW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : {PW{1'b0}};

  function automatic logic signed [PW-1:0] scale(input logic signed [PW-1:0] v);
    return (v + RND_V) >>> SHIFT;
  endfunction

  function automatic logic out_of_range(input logic signed [PW-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
    if (SAT != 0 && v > MAX_V) return MAX_V[WIDTH-1:0];
    if (SAT != 0 && v < MIN_V) return MIN_V[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  logic                    advance;
  logic                    vld_p0, vld_p1, vld_p2;
  logic signed [WIDTH-1:0] ar_p0, ai_p0, br_p0, bi_p0;
  logic                    conj_p0;
  logic signed [PRW-1:0]   rr_p1, ii_p1, ri_p1, ir_p1;
  logic                    conj_p1;
  logic signed [WIDTH-1:0] re_p2, im_p2;
  logic                    ovf_p2;
  logic                    sticky;
  logic signed [PW-1:0]    re_full, im_full, re_sc, im_sc;

  assign advance        = !vld_p2 || bus.out_ready;
  assign bus.in_ready   = advance;
  assign bus.out_valid  = vld_p2;
  assign bus.m_re       = re_p2;
  assign bus.m_im       = im_p2;
  assign bus.ovf        = ovf_p2;
  assign bus.ovf_sticky = sticky;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p0 <= bus.in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage 0 -> 1: operand capture, then the four partial products
  always_ff @(posedge clock) begin
    if (advance) begin
      ar_p0   <= bus.a_re;
      ai_p0   <= bus.a_im;
      br_p0   <= bus.b_re;
      bi_p0   <= bus.b_im;
      conj_p0 <= bus.conj_b;
      rr_p1   <= PRW'(ar_p0) * PRW'(br_p0);
      ii_p1   <= PRW'(ai_p0) * PRW'(bi_p0);
      ri_p1   <= PRW'(ar_p0) * PRW'(bi_p0);
      ir_p1   <= PRW'(ai_p0) * PRW'(br_p0);
      conj_p1 <= conj_p0;
    end
  end

  // Stage 2: combine at full precision, then round/shift/saturate into the output register
  always_comb begin
    if (conj_p1) begin
      re_full = PW'(rr_p1) + PW'(ii_p1);
      im_full = PW'(ir_p1) - PW'(ri_p1);
    end else begin
      re_full = PW'(rr_p1) - PW'(ii_p1);
      im_full = PW'(ri_p1) + PW'(ir_p1);
    end
    re_sc = scale(re_full);
    im_sc = scale(im_full);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      re_p2  <= '0;
      im_p2  <= '0;
      ovf_p2 <= 1'b0;
    end else if (advance) begin
      re_p2  <= saturate(re_sc);
      im_p2  <= saturate(im_sc);
      ovf_p2 <= out_of_range(re_sc) || out_of_range(im_sc);
    end
  end

  // clr wins over a same-cycle overflowing transfer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              sticky <= 1'b0;
    else if (bus.clr)                          sticky <= 1'b0;
    else if (vld_p2 && bus.out_ready && ovf_p2) sticky <= 1'b1;
  end
endmodule

// File: tb/tb_complex_mult_pipe.sv
// Directed plus randomized bench for complex_mult_pipe against an arithmetic reference model.
module tb_complex_mult_pipe;
  localparam int WIDTH = 16;
  localparam int SHIFT = 9;
  localparam int ROUND = 1;

  typedef struct {
    int re;
    int im;
    bit ov;
  } res_t;

  logic clock;
  logic reset_n;
  int   n_total;
  int   n_pass;
  bit   sticky_m;
  res_t exp_q[$];

  int cur_ar, cur_ai, cur_br, cur_bi;
  bit cur_cj, cur_clr;

  complex_mult_pipe_if #(.WIDTH(WIDTH)) bus ();

  complex_mult_pipe dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic longint scl(input longint v);
    longint t;
    t = v;
    if (ROUND != 0 && SHIFT > 0) t = t + (64'sd1 <<< (SHIFT - 1));
    return t >>> SHIFT;
  endfunction

  function automatic int lim(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic res_t ref_model(input int ar, input int ai, input int br, input int bi, input bit cj);
    longint re, im;
    res_t r;
    if (!cj) begin
      re = longint'(ar) * br - longint'(ai) * bi;
      im = longint'(ar) * bi + longint'(ai) * br;
    end else begin
      re = longint'(ar) * br + longint'(ai) * bi;
      im = longint'(ai) * br - longint'(ar) * bi;
    end
    re = scl(re);
    im = scl(im);
    r.ov = (re > 32767) || (re < -32768) || (im > 32767) || (im < -32768);
    r.re = lim(re);
    r.im = lim(im);
    return r;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input bit iv, input int ar, input int ai, input int br, input int bi,
                       input bit cj, input bit ordy, input bit cl);
    cur_ar = ar; cur_ai = ai; cur_br = br; cur_bi = bi; cur_cj = cj; cur_clr = cl;
    bus.in_valid  = iv;
    bus.a_re      = 16'(ar);
    bus.a_im      = 16'(ai);
    bus.b_re      = 16'(br);
    bus.b_im      = 16'(bi);
    bus.conj_b    = cj;
    bus.out_ready = ordy;
    bus.clr       = cl;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 0, 0, 0, 0, 1'b0, ordy, 1'b0);
  endtask

  // One clock: sample handshakes mid-cycle, score transfers, advance, check sticky flag.
  task automatic tick(output bit acc);
    bit   xfer;
    bit   ov_x;
    res_t e;
    #1;
    acc  = bus.in_valid && bus.in_ready;
    xfer = bus.out_valid && bus.out_ready;
    ov_x = 1'b0;
    chk("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        ov_x = e.ov;
        chk("m_re", bus.m_re, e.re);
        chk("m_im", bus.m_im, e.im);
        chk("ovf", bus.ovf, e.ov);
      end
    end
    if (acc) exp_q.push_back(ref_model(cur_ar, cur_ai, cur_br, cur_bi, cur_cj));
    if (cur_clr) sticky_m = 1'b0;
    else if (ov_x) sticky_m = 1'b1;
    @(posedge clock);
    #1;
    chk("ovf_sticky", bus.ovf_sticky, sticky_m);
  endtask

  initial begin
    bit acc;
    int k;
    int rexp[4];
    int rb[4];
    n_total  = 0;
    n_pass   = 0;
    sticky_m = 1'b0;
    reset_n  = 1'b0;
    idle(1'b1);

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_m_re", bus.m_re, 0);
    chk("rst_m_im", bus.m_im, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_sticky", bus.ovf_sticky, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Basic latency: out_valid exactly three edges after acceptance
    drive(1'b1, 512, 0, 100, -50, 1'b0, 1'b1, 1'b0);
    tick(acc);
    chk("lat_acc", acc, 1);
    chk("lat_e1", bus.out_valid, 0);
    idle(1'b1); tick(acc);
    chk("lat_e2", bus.out_valid, 0);
    idle(1'b1); tick(acc);
    chk("lat_e3", bus.out_valid, 1);
    chk("lat_re", bus.m_re, 100);
    chk("lat_im", bus.m_im, -50);
    chk("lat_ovf", bus.ovf, 0);
    idle(1'b1); tick(acc);

    // Back-to-back with conj toggle
    drive(1'b1, 0, 512, 0, 512, 1'b0, 1'b1, 1'b0); tick(acc);
    drive(1'b1, 0, 512, 0, 512, 1'b1, 1'b1, 1'b0); tick(acc);
    idle(1'b1); tick(acc);
    chk("b2b_v0", bus.out_valid, 1);
    chk("b2b_re0", bus.m_re, -512);
    chk("b2b_im0", bus.m_im, 0);
    idle(1'b1); tick(acc);
    chk("b2b_v1", bus.out_valid, 1);
    chk("b2b_re1", bus.m_re, 512);
    chk("b2b_im1", bus.m_im, 0);
    idle(1'b1); tick(acc);
    chk("b2b_done", bus.out_valid, 0);

    // Rounding boundaries
    rb   = '{256, 255, -256, -257};
    rexp = '{1, 0, 0, -1};
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, 1, 0, rb[i], 0, 1'b0, 1'b1, 1'b0);
      else idle(1'b1);
      tick(acc);
      if (bus.out_valid && k < 4) begin
        chk("round", bus.m_re, rexp[k]);
        k++;
      end
    end
    chk("round_count", k, 4);

    // Saturation, sticky set on transfer, clr
    drive(1'b1, 32767, 0, 32767, 0, 1'b0, 1'b1, 1'b0); tick(acc);
    idle(1'b1); tick(acc);
    idle(1'b1); tick(acc);
    chk("sat_valid", bus.out_valid, 1);
    chk("sat_re", bus.m_re, 32767);
    chk("sat_ovf", bus.ovf, 1);
    idle(1'b1); tick(acc);
    chk("sticky_set", bus.ovf_sticky, 1);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1); tick(acc);
    chk("sticky_clr", bus.ovf_sticky, 0);

    // Backpressure: three fill the pipe, fourth waits, outputs held
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 1000, s * 100 + 7, 300, -200 + s, s[0], 1'b0, 1'b0);
      tick(acc);
      chk("bp_acc", acc, 1);
    end
    drive(1'b1, 1000, 307, 300, -197, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      tick(acc);
      chk("bp_stall_acc", acc, 0);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_re", bus.m_re, exp_q[0].re);
      chk("bp_hold_im", bus.m_im, exp_q[0].im);
    end
    drive(1'b1, 1000, 307, 300, -197, 1'b1, 1'b1, 1'b0);
    tick(acc);
    chk("bp_acc4", acc, 1);
    for (int s = 0; s < 6; s++) begin
      idle(1'b1);
      tick(acc);
    end
    chk("bp_drained", exp_q.size(), 0);

    // Asynchronous reset with samples in flight
    drive(1'b1, 700, 30, 400, 20, 1'b0, 1'b1, 1'b0); tick(acc);
    drive(1'b1, 600, 10, 500, 40, 1'b1, 1'b1, 1'b0); tick(acc);
    idle(1'b1); tick(acc);
    chk("ar_pre_valid", bus.out_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("ar_valid", bus.out_valid, 0);
    chk("ar_re", bus.m_re, 0);
    chk("ar_im", bus.m_im, 0);
    chk("ar_in_ready", bus.in_ready, 1);
    exp_q.delete();
    sticky_m = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int s = 0; s < 5; s++) begin
      idle(1'b1);
      tick(acc);
      chk("ar_no_stale", bus.out_valid, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      int ar, ai, br, bi;
      if ($urandom_range(0, 1) == 0) begin
        ar = int'($urandom_range(0, 65535)) - 32768;
        ai = int'($urandom_range(0, 65535)) - 32768;
        br = int'($urandom_range(0, 65535)) - 32768;
        bi = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        ar = int'($urandom_range(0, 4000)) - 2000;
        ai = int'($urandom_range(0, 4000)) - 2000;
        br = int'($urandom_range(0, 4000)) - 2000;
        bi = int'($urandom_range(0, 4000)) - 2000;
      end
      drive($urandom_range(0, 3) != 0, ar, ai, br, bi, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      tick(acc);
    end
    for (int s = 0; s < 8; s++) begin
      idle(1'b1);
      tick(acc);
    end
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_idle_valid", bus.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
